instr_queue: RTL and testbench

Upstream instruction feeder for the compute unit. Assembles 16-bit instructions from a byte-serial input stream (high byte first) and buffers them in a small FIFO. Issues them one per cycle through a valid/ready handshake, so the compute unit sees whole instructions instead of raw pin values.

---
 rtl/instr_queue.sv | 173 +++++++++++++++++
 tb/tb_instr_queue.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - byte-serial instruction assembler feeding a FWFT FIFO
//
// Purpose:
//   Assembles 16-bit instructions from a byte stream (high byte first) and
//   queues them in a 2**ADDR_W entry first-word-fall-through FIFO, issued to
//   the compute unit over a valid/ready handshake.
//
// Ports:
//   clk, rst_n        - clock (rising edge), asynchronous active-low reset
//   ena               - global enable; when low all state holds
//   byte_in, byte_wr  - instruction byte and its strobe
//   flush             - synchronous clear of FIFO, assembler and flags
//   instr_out         - head-of-queue instruction (0 when empty)
//   instr_valid       - instr_out valid (!empty && ena)
//   instr_ready       - consumer accepts instr_out this cycle
//   count/full/empty  - occupancy, 0..DEPTH
//   overflow          - sticky: an instruction was dropped on a full FIFO
//   illegal_cnt       - saturating count of filtered illegal opcodes
//
// Build option:
//   ILLEGAL_OP_FILTER_EN - when defined, instructions with opcode [15:12] >= 8
//   are dropped and counted in illegal_cnt; otherwise illegal_cnt is 0.

module instr_queue #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [7:0]        byte_in,
  input  logic              byte_wr,
  input  logic              flush,
  output logic [15:0]       instr_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic [7:0]        illegal_cnt
);

  localparam int              LP_DEPTH_I = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LP_DEPTH   = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic {
    HI_WAIT = 1'b0,
    LO_WAIT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_hi;
  logic [15:0]         r_mem [LP_DEPTH_I];
  logic [ADDR_W-1:0]   r_wptr;
  logic [ADDR_W-1:0]   r_rptr;
  logic [ADDR_W:0]     r_count;
  logic                r_overflow;

  logic                w_flush;
  logic                w_wr;
  logic                w_pop;
  logic [15:0]         w_word;
  logic                w_asm_done;
  logic                w_illegal;
  logic                w_push_req;
  logic                w_push;
  logic                w_drop;

  // Flush outranks everything, so a byte or pop on the flush edge is ignored.
  assign w_flush    = ena && flush;
  assign w_wr       = ena && byte_wr && !flush;
  assign w_pop      = instr_valid && instr_ready && !flush;
  assign w_word     = {r_hi, byte_in};
  assign w_asm_done = w_wr && (r_state == LO_WAIT);
  assign w_push_req = w_asm_done && !w_illegal;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_push     = w_push_req && (!full || w_pop);
  assign w_drop     = w_push_req && full && !w_pop;

  // Assembler next-state
  always_comb begin
    w_state_nxt = r_state;
    if (w_wr) begin
      case (r_state)
        HI_WAIT: w_state_nxt = LO_WAIT;
        LO_WAIT: w_state_nxt = HI_WAIT;
        default: w_state_nxt = HI_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HI_WAIT;
      r_hi    <= 8'h00;
    end else if (w_flush) begin
      r_state <= HI_WAIT;
      r_hi    <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr && (r_state == HI_WAIT)) begin
        r_hi <= byte_in;
      end
    end
  end

  // Storage is not reset; it is only visible through instr_out when non-empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (w_flush) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

`ifdef ILLEGAL_OP_FILTER_EN
  logic [7:0] r_illegal_cnt;

  // Opcode >= 4'b1000 is exactly "bit 15 set".
  assign w_illegal = w_word[15];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal_cnt <= 8'h00;
    end else if (w_flush) begin
      r_illegal_cnt <= 8'h00;
    end else if (w_asm_done && w_illegal && (r_illegal_cnt != 8'hFF)) begin
      r_illegal_cnt <= r_illegal_cnt + 8'h01;
    end
  end

  assign illegal_cnt = r_illegal_cnt;
`else
  assign w_illegal   = 1'b0;
  assign illegal_cnt = 8'h00;
`endif

  assign count       = r_count;
  assign empty       = (r_count == '0);
  assign full        = (r_count == LP_DEPTH);
  assign overflow    = r_overflow;
  assign instr_valid = !empty && ena;
  assign instr_out   = empty ? 16'h0000 : r_mem[r_rptr];

endmodule

// File: tb/tb_instr_queue.sv
// tb/tb_instr_queue.sv - directed vector bench for instr_queue

module tb_instr_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [7:0]  byte_in;
  logic        byte_wr;
  logic        flush;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;
  logic [7:0]  illegal_cnt;

  int n_vec = 0;
  int n_bad = 0;

`ifdef ILLEGAL_OP_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  instr_queue #(.ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .byte_in(byte_in), .byte_wr(byte_wr),
    .flush(flush), .instr_out(instr_out), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .count(count), .full(full), .empty(empty),
    .overflow(overflow), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        wr;
    logic [7:0]  bin;
    logic        fl;
    logic        rdy;
    logic [15:0] e_out;
    logic        e_vld;
    logic [3:0]  e_cnt;
    logic        e_ovf;
    logic [7:0]  e_ill;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_instr(input logic [15:0] w);
    byte_wr = 1'b1;
    byte_in = w[15:8];
    cyc();
    byte_in = w[7:0];
    cyc();
    byte_wr = 1'b0;
  endtask

  task automatic pop_one();
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
  endtask

  initial begin
    logic [15:0] w;
    rst_n = 1'b0; ena = 1'b1; byte_in = 8'h00; byte_wr = 1'b0;
    flush = 1'b0; instr_ready = 1'b0;

    // en wr bin fl rdy | out vld cnt ovf ill
    vecs.push_back('{1, 1, 8'h12, 0, 0, 16'h0000, 0, 4'd0, 0, 8'd0});
    vecs.push_back('{1, 1, 8'h34, 0, 0, 16'h1234, 1, 4'd1, 0, 8'd0});
    vecs.push_back('{1, 0, 8'h00, 0, 1, 16'h0000, 0, 4'd0, 0, 8'd0});
    vecs.push_back('{1, 1, 8'hAB, 0, 0, 16'h0000, 0, 4'd0, 0, 8'd0});
    vecs.push_back('{1, 0, 8'h00, 1, 0, 16'h0000, 0, 4'd0, 0, 8'd0});
    vecs.push_back('{1, 1, 8'h10, 0, 0, 16'h0000, 0, 4'd0, 0, 8'd0});
    vecs.push_back('{1, 1, 8'h05, 0, 0, 16'h1005, 1, 4'd1, 0, 8'd0});
    vecs.push_back('{1, 1, 8'h80, 0, 0, 16'h1005, 1, 4'd1, 0, 8'd0});
    vecs.push_back('{1, 1, 8'h00, 0, 0, 16'h1005, 1, FILT ? 4'd1 : 4'd2, 0, FILT ? 8'd1 : 8'd0});
    vecs.push_back('{0, 1, 8'h22, 0, 1, 16'h1005, 0, FILT ? 4'd1 : 4'd2, 0, FILT ? 8'd1 : 8'd0});
    vecs.push_back('{0, 1, 8'h33, 0, 1, 16'h1005, 0, FILT ? 4'd1 : 4'd2, 0, FILT ? 8'd1 : 8'd0});
    vecs.push_back('{1, 0, 8'h00, 0, 1, FILT ? 16'h0000 : 16'h8000, !FILT, FILT ? 4'd0 : 4'd1, 0, FILT ? 8'd1 : 8'd0});
    vecs.push_back('{1, 0, 8'h00, 0, 1, 16'h0000, 0, 4'd0, 0, FILT ? 8'd1 : 8'd0});
    vecs.push_back('{1, 1, 8'h77, 1, 0, 16'h0000, 0, 4'd0, 0, 8'd0});
    vecs.push_back('{1, 1, 8'h12, 0, 0, 16'h0000, 0, 4'd0, 0, 8'd0});
    vecs.push_back('{1, 1, 8'h34, 0, 0, 16'h1234, 1, 4'd1, 0, 8'd0});
    vecs.push_back('{1, 0, 8'h00, 0, 1, 16'h0000, 0, 4'd0, 0, 8'd0});

    // Reset state
    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_out", 32'(instr_out), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_ill", 32'(illegal_cnt), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      ena = vecs[i].en; byte_wr = vecs[i].wr; byte_in = vecs[i].bin;
      flush = vecs[i].fl; instr_ready = vecs[i].rdy;
      cyc();
      chk($sformatf("v%0d_out", i), 32'(instr_out), 32'(vecs[i].e_out));
      chk($sformatf("v%0d_vld", i), 32'(instr_valid), 32'(vecs[i].e_vld));
      chk($sformatf("v%0d_cnt", i), 32'(count), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].e_cnt == 4'd0));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
      chk($sformatf("v%0d_ill", i), 32'(illegal_cnt), 32'(vecs[i].e_ill));
    end
    ena = 1'b1; byte_wr = 1'b0; flush = 1'b0; instr_ready = 1'b0;

    // Fill and overflow
    do_flush();
    for (int i = 0; i < 8; i++) push_instr(16'h1000 + 16'(i));
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ovf0", 32'(overflow), 32'd0);
    push_instr(16'h1008);
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d", i), 32'(instr_out), 32'(16'h1000 + 16'(i)));
      chk($sformatf("drain%0d_vld", i), 32'(instr_valid), 32'd1);
      pop_one();
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_out0", 32'(instr_out), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    do_flush();
    chk("flush_ovf", 32'(overflow), 32'd0);

    // Push and pop on the same edge while full, wrapping the pointers
    for (int i = 0; i < 8; i++) push_instr(16'h2000 + 16'(i));
    for (int k = 0; k < 4; k++) begin
      w = 16'h2008 + 16'(k);
      byte_wr = 1'b1; byte_in = w[15:8];
      cyc();
      byte_in = w[7:0]; instr_ready = 1'b1;
      cyc();
      byte_wr = 1'b0; instr_ready = 1'b0;
      chk($sformatf("pp%0d_cnt", k), 32'(count), 32'd8);
      chk($sformatf("pp%0d_ovf", k), 32'(overflow), 32'd0);
      chk($sformatf("pp%0d_head", k), 32'(instr_out), 32'(16'h2001 + 16'(k)));
    end
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("wrap%0d", i), 32'(instr_out), 32'(16'h2004 + 16'(i)));
      pop_one();
    end
    chk("wrap_empty", 32'(empty), 32'd1);

    // Asynchronous reset mid-cycle with queued data and a latched high byte
    for (int i = 0; i < 3; i++) push_instr(16'h3000 + 16'(i));
    byte_wr = 1'b1; byte_in = 8'h55;
    cyc();
    byte_wr = 1'b0;
    chk("pre_rst_cnt", 32'(count), 32'd3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_valid", 32'(instr_valid), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    chk("arst_out", 32'(instr_out), 32'd0);
    cyc();
    rst_n = 1'b1;
    ena = 1'b0;
    push_instr(16'h1122);
    ena = 1'b1;
    cyc();
    chk("ena0_count", 32'(count), 32'd0);
    chk("ena0_empty", 32'(empty), 32'd1);
    push_instr(16'h1234);
    chk("post_rst_out", 32'(instr_out), 32'h1234);
    chk("post_rst_cnt", 32'(count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
